hdmi_timing_gen: RTL and testbench

//  Raster timing generator feeding the 8-pixel framebuffer fetch stage: emits hs/vs/de plus x/y.

---
 rtl/hdmi_timing_gen_pkg.sv | 37 +++
 rtl/hdmi_timing_gen_phase_counter.sv | 70 +++++++
 rtl/hdmi_timing_gen.sv | 132 +++++++++++++
 tb/tb_hdmi_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_gen_pkg.sv
// =============================================================================
// hdmi_timing_gen_pkg : shared widths, 1080p timing defaults and phase/state
//                       encodings for the raster timing generator.
// Revision: 1.0
// =============================================================================
`default_nettype none

package hdmi_timing_gen_pkg;

    localparam int HBW = 12;
    localparam int VBW = 11;
    localparam int PBW = 2;

    localparam int HDMI_H_ACTIVE = 1920;
    localparam int HDMI_H_FP     = 88;
    localparam int HDMI_H_SYNC   = 44;
    localparam int HDMI_H_BP     = 148;
    localparam int HDMI_V_ACTIVE = 1080;
    localparam int HDMI_V_FP     = 4;
    localparam int HDMI_V_SYNC   = 5;
    localparam int HDMI_V_BP     = 36;

    typedef enum logic [PBW-1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_e;

endpackage

`default_nettype wire

// File: rtl/hdmi_timing_gen_phase_counter.sv
// =============================================================================
// hdmi_phase_counter : one raster axis; counter plus ACTIVE/FP/SYNC/BP phase
//                      FSM, with next-state outputs so the parent can register
//                      its decoded syncs in step with the counter.
// Revision: 1.0
// =============================================================================
`default_nettype none

module hdmi_phase_counter
    import hdmi_timing_gen_pkg::*;
#(
    parameter int W      = HBW,
    parameter int ACTIVE = HDMI_H_ACTIVE,
    parameter int FP     = HDMI_H_FP,
    parameter int SYNC   = HDMI_H_SYNC,
    parameter int BP     = HDMI_H_BP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         advance_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output phase_e       phase_next_o,
    output logic         wrap_o
);

    localparam int             TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0]   C_ACT_END  = W'(ACTIVE - 1);
    localparam logic [W-1:0]   C_FP_END   = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0]   C_SYNC_END = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0]   C_LAST     = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    phase_e       phase_q, phase_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    // Phase steps on the last count of the current phase, so the phase
    // register changes on the same edge as the counter crosses the boundary.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (advance_i) begin
            count_d = (count_q == C_LAST) ? '0 : count_q + W'(1);
            case (phase_q)
                PH_ACTIVE: if (count_q == C_ACT_END)  phase_d = PH_FP;
                PH_FP:     if (count_q == C_FP_END)   phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == C_SYNC_END) phase_d = PH_BP;
                PH_BP:     if (count_q == C_LAST)     phase_d = PH_ACTIVE;
                default:                              phase_d = PH_ACTIVE;
            endcase
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign phase_next_o = phase_d;
    assign wrap_o       = advance_i && (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/hdmi_timing_gen.sv
// =============================================================================
// hdmi_timing_gen : free-running raster timing generator (hs/vs/de, x/y,
//                   line/frame pulses). Optional frame counter is built when
//                   HDMI_TIMING_FRAME_CNT_EN is defined.
// Revision: 1.0
// =============================================================================
`default_nettype none

module hdmi_timing_gen
    import hdmi_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = HDMI_H_ACTIVE,
    parameter int   H_FP     = HDMI_H_FP,
    parameter int   H_SYNC   = HDMI_H_SYNC,
    parameter int   H_BP     = HDMI_H_BP,
    parameter int   V_ACTIVE = HDMI_V_ACTIVE,
    parameter int   V_FP     = HDMI_V_FP,
    parameter int   V_SYNC   = HDMI_V_SYNC,
    parameter int   V_BP     = HDMI_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic           clock_i,
    input  logic           reset_i,
    input  logic           enable_i,
    output logic           hs_o,
    output logic           vs_o,
    output logic           de_o,
    output logic [HBW-1:0] x_o,
    output logic [VBW-1:0] y_o,
    output logic           line_start_o,
`ifdef HDMI_TIMING_FRAME_CNT_EN
    output logic           frame_start_o,
    output logic [15:0]    frame_count_o
`else
    output logic           frame_start_o
`endif
);

    run_e           state_q, state_d;
    logic           running, run_next;
    logic [HBW-1:0] x_d;
    logic [VBW-1:0] y_d;
    phase_e         h_phase_d, v_phase_d;
    logic           h_wrap, v_wrap;
    logic           de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic           ls_q, ls_d, fs_q, fs_d;

    assign running = (state_q == ST_RUN);

    hdmi_phase_counter #(
        .W(HBW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_cnt (
        .clk_i        (clock_i),
        .rst_i        (reset_i),
        .advance_i    (running),
        .count_o      (x_o),
        .count_next_o (x_d),
        .phase_next_o (h_phase_d),
        .wrap_o       (h_wrap)
    );

    hdmi_phase_counter #(
        .W(VBW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_cnt (
        .clk_i        (clock_i),
        .rst_i        (reset_i),
        .advance_i    (h_wrap),
        .count_o      (y_o),
        .count_next_o (y_d),
        .phase_next_o (v_phase_d),
        .wrap_o       (v_wrap)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    // Enable is only honoured at frame boundaries once running; outputs are
    // decoded from next-state so they land on the same edge as x/y.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i)            state_d = ST_RUN;
            ST_RUN:  if (v_wrap && !enable_i) state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
        run_next = (state_d == ST_RUN);
        de_d     = run_next && (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
        hs_d     = (run_next && (h_phase_d == PH_SYNC)) ? HS_POL : ~HS_POL;
        vs_d     = (run_next && (v_phase_d == PH_SYNC)) ? VS_POL : ~VS_POL;
        ls_d     = run_next && (x_d == '0);
        fs_d     = ls_d && (y_d == '0);
    end

    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign de_o          = de_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;

`ifdef HDMI_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            frame_count_q <= '0;
        end else if (fs_d) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count_o = frame_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
// =============================================================================
// tb_hdmi_timing_gen : self-checking bench for hdmi_timing_gen on a reduced
//                      raster, compared against an x/y arithmetic model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_hdmi_timing_gen;
    import hdmi_timing_gen_pkg::*;

    localparam int   C_HA = 16, C_HF = 3, C_HS = 4, C_HB = 5;
    localparam int   C_VA = 6,  C_VF = 2, C_VS = 3, C_VB = 2;
    localparam int   C_HT = C_HA + C_HF + C_HS + C_HB;
    localparam int   C_VT = C_VA + C_VF + C_VS + C_VB;
    localparam logic C_HS_POL = 1'b1;
    localparam logic C_VS_POL = 1'b0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic           hs, vs, de, ls, fs;
    logic [HBW-1:0] x;
    logic [VBW-1:0] y;
    logic [27:0]    obs;
`ifdef HDMI_TIMING_FRAME_CNT_EN
    logic [15:0]    fc;
`endif

    always #5 clk = ~clk;

    hdmi_timing_gen #(
        .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
        .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
        .HS_POL(C_HS_POL), .VS_POL(C_VS_POL)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .hs_o          (hs),
        .vs_o          (vs),
        .de_o          (de),
        .x_o           (x),
        .y_o           (y),
        .line_start_o  (ls),
`ifdef HDMI_TIMING_FRAME_CNT_EN
        .frame_start_o (fs),
        .frame_count_o (fc)
`else
        .frame_start_o (fs)
`endif
    );

    assign obs = {hs, vs, de, ls, fs, x, y};

    int checks = 0;
    int errors = 0;

    // Reference model: running flag, raster position, frames started
    bit m_run = 1'b0;
    int m_x   = 0;
    int m_y   = 0;
    int m_fc  = 0;

    localparam logic [27:0] C_RESET_VEC = {~C_HS_POL, ~C_VS_POL, 3'b000, 12'd0, 11'd0};

    function automatic logic [27:0] exp_vec();
        logic e_de, e_hs, e_vs, e_ls, e_fs;
        logic [11:0] ex;
        logic [10:0] ey;
        e_de = m_run && (m_x < C_HA) && (m_y < C_VA);
        e_hs = (m_run && m_x >= C_HA + C_HF && m_x < C_HA + C_HF + C_HS) ? C_HS_POL : ~C_HS_POL;
        e_vs = (m_run && m_y >= C_VA + C_VF && m_y < C_VA + C_VF + C_VS) ? C_VS_POL : ~C_VS_POL;
        e_ls = m_run && (m_x == 0);
        e_fs = e_ls && (m_y == 0);
        ex   = 12'(m_x);
        ey   = 11'(m_y);
        return {e_hs, e_vs, e_de, e_ls, e_fs, ex, ey};
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_x = 0; m_y = 0; m_fc = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_fc  = (m_fc + 1) % 65536;
            end
        end else if (m_x == C_HT - 1) begin
            m_x = 0;
            if (m_y == C_VT - 1) begin
                m_y = 0;
                if (en) m_fc = (m_fc + 1) % 65536;
                else    m_run = 1'b0;
            end else begin
                m_y = m_y + 1;
            end
        end else begin
            m_x = m_x + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== C_RESET_VEC) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, C_RESET_VEC);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({de, ls, fs, x, y} !== {3'b111, 23'd0}) begin
            errors++;
            $display("FAIL reset_release_start: got de=%b ls=%b fs=%b x=%0d y=%0d expected 1 1 1 0 0",
                     de, ls, fs, x, y);
        end
    endtask

    task automatic test_line();
        int de_cnt = 0, hs_cnt = 0, ls_cnt = 0, hs_first = -1;
        for (int i = 0; i < C_HT; i++) begin
            if (de === 1'b1) de_cnt++;
            if (ls === 1'b1) ls_cnt++;
            if (hs === C_HS_POL) begin
                if (hs_first < 0) hs_first = int'(x);
                hs_cnt++;
            end
            tick();
        end
        checks++;
        if (de_cnt != C_HA) begin
            errors++; $display("FAIL line_de_count: got %0d expected %0d", de_cnt, C_HA);
        end
        checks++;
        if (hs_cnt != C_HS || hs_first != C_HA + C_HF) begin
            errors++;
            $display("FAIL line_hs_window: got start %0d len %0d expected start %0d len %0d",
                     hs_first, hs_cnt, C_HA + C_HF, C_HS);
        end
        checks++;
        if (ls_cnt != 1 || ls !== 1'b1 || y !== 11'd1) begin
            errors++;
            $display("FAIL line_start_period: got count %0d ls=%b y=%0d expected 1 1 1", ls_cnt, ls, y);
        end
    endtask

    task automatic test_frame();
        int de_cnt = 0, vs_cnt = 0, extra_fs = 0, rise_x = -1, rise_y = -1;
        bit prev_act = 1'b0, found = 1'b0;
        for (int i = 0; i < C_HT * C_VT + 4 && !found; i++) begin
            if (fs === 1'b1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL frame_wait: got no frame_start expected one within a frame");
        end
        for (int i = 0; i < C_HT * C_VT; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL frame_cycle[%0d]: got %h expected %h", i, obs, exp_vec());
            end
            if (de === 1'b1) de_cnt++;
            if (i > 0 && fs === 1'b1) extra_fs++;
            if (vs === C_VS_POL) begin
                vs_cnt++;
                if (!prev_act) begin rise_x = int'(x); rise_y = int'(y); end
            end
            prev_act = (vs === C_VS_POL);
            tick();
        end
        checks++;
        if (de_cnt != C_HA * C_VA) begin
            errors++; $display("FAIL frame_de_count: got %0d expected %0d", de_cnt, C_HA * C_VA);
        end
        checks++;
        if (vs_cnt != C_VS * C_HT || rise_x != 0 || rise_y != C_VA + C_VF) begin
            errors++;
            $display("FAIL frame_vs_window: got len %0d at x=%0d y=%0d expected len %0d at x=0 y=%0d",
                     vs_cnt, rise_x, rise_y, C_VS * C_HT, C_VA + C_VF);
        end
        checks++;
        if (fs !== 1'b1 || extra_fs != 0) begin
            errors++;
            $display("FAIL frame_start_period: got fs=%b extra=%0d expected fs=1 extra=0", fs, extra_fs);
        end
    endtask

    task automatic test_enable_drop();
        int last_x = -1, last_y = -1, fs_cnt = 0, noisy = 0;
        for (int i = 0; i < C_HT * C_VT && !(m_y == C_VA / 2 && m_x == 0); i++) tick();
        en = 1'b0;
        for (int i = 0; i < C_HT * C_VT + 4 && m_run; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL drop_cycle[%0d]: got %h expected %h", i, obs, exp_vec());
            end
            last_x = int'(x); last_y = int'(y);
            tick();
        end
        checks++;
        if (last_x != C_HT - 1 || last_y != C_VT - 1) begin
            errors++;
            $display("FAIL drop_completes_frame: got last x=%0d y=%0d expected %0d %0d",
                     last_x, last_y, C_HT - 1, C_VT - 1);
        end
        for (int i = 0; i < 20; i++) begin
            if (obs !== C_RESET_VEC) noisy++;
            if (fs === 1'b1) fs_cnt++;
            tick();
        end
        checks++;
        if (noisy != 0 || fs_cnt != 0) begin
            errors++;
            $display("FAIL drop_idle_quiet: got %0d active cycles %0d frame_starts expected 0 0", noisy, fs_cnt);
        end
    endtask

    task automatic test_reenable();
        int gap;
        en = 1'b1;
        tick();
        for (int i = 0; i < C_HT * C_VT && m_y != 2; i++) tick();
        en  = 1'b0;
        gap = int'($urandom_range(1, 3 * C_HT));
        repeat (gap) tick();
        en = 1'b1;
        for (int i = 0; i < C_HT * C_VT && !(m_x == 0 && m_y == 0); i++) tick();
        checks++;
        if (fs !== 1'b1 || de !== 1'b1 || x !== 12'd0 || y !== 11'd0) begin
            errors++;
            $display("FAIL reenable_seamless: got fs=%b de=%b x=%0d y=%0d expected 1 1 0 0", fs, de, x, y);
        end
    endtask

    task automatic test_reset_mid();
        repeat (int'($urandom_range(5, C_HT * 3))) tick();
        rst = 1'b1; en = 1'b1;
        tick();
        checks++;
        if (obs !== C_RESET_VEC) begin
            errors++; $display("FAIL reset_mid_frame: got %h expected %h", obs, C_RESET_VEC);
        end
`ifdef HDMI_TIMING_FRAME_CNT_EN
        checks++;
        if (fc !== 16'd0) begin
            errors++; $display("FAIL reset_mid_count: got %h expected 0000", fc);
        end
`endif
        rst = 1'b0;
    endtask

`ifdef HDMI_TIMING_FRAME_CNT_EN
    task automatic test_frame_count_wrap();
        en = 1'b1;
        tick();
        checks++;
        if (fc !== 16'd1) begin
            errors++; $display("FAIL count_first_frame: got %h expected 0001", fc);
        end
        @(negedge clk);
        dut.frame_count_q = 16'hFFFF;
        m_fc = 16'hFFFF;
        tick();
        for (int i = 0; i < C_HT * C_VT && !(m_x == 0 && m_y == 0); i++) tick();
        checks++;
        if (fc !== 16'h0000 || fs !== 1'b1) begin
            errors++; $display("FAIL count_wrap: got %h fs=%b expected 0000 fs=1", fc, fs);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (i % 37 == 0) en = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 499) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_cycle[%0d]: got %h expected %h", i, obs, exp_vec());
            end
`ifdef HDMI_TIMING_FRAME_CNT_EN
            checks++;
            if (fc !== 16'(m_fc)) begin
                errors++; $display("FAIL random_count[%0d]: got %h expected %h", i, fc, 16'(m_fc));
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_enable_drop();
        test_reenable();
        test_reset_mid();
`ifdef HDMI_TIMING_FRAME_CNT_EN
        test_frame_count_wrap();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
